// File: rtl/ula_nibble_sequencer.sv
// ula_nibble_sequencer
//   Drives a single external 4-bit 74181-style ULA one nibble per clock,
//   LSB nibble first. It chains carry/borrow between nibbles and assembles
//   the full-width result, the final carry and an all-nibbles equality flag.
//   The command side and the result side each use a ready/valid handshake.
//
//   Optional feature macro: ULA_SEQ_ZERO_FLAG_EN
//     When defined, adds output res_zero = (assembled res_f == 0). It is
//     registered with the final nibble and held in DONE with the other results.
module ula_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_c_in,
    output logic [3:0]       ula_a,
    output logic [3:0]       ula_b,
    output logic [3:0]       ula_s,
    output logic             ula_m,
    output logic             ula_c_in,
    output logic             ula_b_in,
    input  logic [3:0]       ula_f,
    input  logic             ula_c_out,
    input  logic             ula_a_eq_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_c_out,
    output logic             res_a_eq_b
`ifdef ULA_SEQ_ZERO_FLAG_EN
    ,
    output logic             res_zero
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic             carry_next;
    logic             eq_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] res_f_reg;
    logic [WIDTH-1:0] res_f_next;
    logic             res_c_out_reg;
    logic             res_a_eq_b_reg;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    logic             res_zero_reg;
`endif

    logic [3:0]       cur_a;
    logic [3:0]       cur_b;
    logic             last_nib;
    logic             borrow_op;
    logic [NIB-1:0]   nib_hit;

    assign last_nib = (idx_reg == LAST_IDX);

    // Ops whose raw c_out is a borrow; the next nibble wants the inverted sense.
    assign borrow_op = (s_reg == 4'b0110) || (s_reg == 4'b0111) ||
                       (s_reg == 4'b1011) || (s_reg == 4'b1111);

    // Select the latched operand nibble addressed by idx.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_a = a_reg[4*i +: 4];
                cur_b = b_reg[4*i +: 4];
            end
        end
    end

    // Carry into the next nibble: logic mode and s=0011 reuse the command carry.
    always_comb begin
        carry_next = ula_c_out;
        if (m_reg || (s_reg == 4'b0011)) begin
            carry_next = cin_reg;
        end else if (borrow_op) begin
            carry_next = ~ula_c_out;
        end
    end

    // Only the nibble currently being computed is replaced in the result.
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign nib_hit[gi] = (state_reg == RUN) && (idx_reg == IDX_W'(gi));
            assign res_f_next[4*gi +: 4] = nib_hit[gi] ? ula_f : res_f_reg[4*gi +: 4];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and ULA drive; the ULA inputs are quiet outside RUN.
    always_comb begin
        state_next = state_reg;
        ula_a      = 4'd0;
        ula_b      = 4'd0;
        ula_s      = 4'd0;
        ula_m      = 1'b0;
        ula_c_in   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ula_a    = cur_a;
                ula_b    = cur_b;
                ula_s    = s_reg;
                ula_m    = m_reg;
                ula_c_in = carry_reg;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture and per-nibble accumulation of result, carry and equality.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg          <= '0;
            b_reg          <= '0;
            s_reg          <= 4'd0;
            m_reg          <= 1'b0;
            cin_reg        <= 1'b0;
            carry_reg      <= 1'b0;
            eq_reg         <= 1'b0;
            idx_reg        <= '0;
            res_f_reg      <= '0;
            res_c_out_reg  <= 1'b0;
            res_a_eq_b_reg <= 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
            res_zero_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        s_reg     <= op_s;
                        m_reg     <= op_m;
                        cin_reg   <= op_c_in;
                        carry_reg <= op_c_in;
                        eq_reg    <= 1'b1;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    res_f_reg <= res_f_next;
                    eq_reg    <= eq_reg & ula_a_eq_b;
                    carry_reg <= carry_next;
                    if (last_nib) begin
                        res_c_out_reg  <= ula_c_out;
                        res_a_eq_b_reg <= eq_reg & ula_a_eq_b;
`ifdef ULA_SEQ_ZERO_FLAG_EN
                        res_zero_reg   <= (res_f_next == '0);
`endif
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign ula_b_in   = 1'b0;
    assign res_f      = res_f_reg;
    assign res_c_out  = res_c_out_reg;
    assign res_a_eq_b = res_a_eq_b_reg;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    assign res_zero   = res_zero_reg;
`endif

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// tb_ula_nibble_sequencer
//   Random and directed commands for the nibble sequencer with a behavioural
//   74181-style ULA attached. Expected results come from a full-width
//   arithmetic reference and are queued when a command is accepted; a
//   monitor pops and compares when out_valid rises, and checks that results
//   hold while the consumer stalls.
module tb_ula_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_s;
    logic             op_m;
    logic             op_c_in;
    logic [3:0]       ula_a;
    logic [3:0]       ula_b;
    logic [3:0]       ula_s;
    logic             ula_m;
    logic             ula_c_in;
    logic             ula_b_in;
    logic [3:0]       ula_f;
    logic             ula_c_out;
    logic             ula_a_eq_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_f;
    logic             res_c_out;
    logic             res_a_eq_b;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    logic             res_zero;
`endif

    logic bp_en;
    logic rand_ready;
    logic man_ready;
    int   cyc;
    int   checks;
    int   passes;

    typedef struct {
        logic [15:0] f;
        logic        c;
        logic        eq;
        int          acc;
    } exp_t;

    exp_t sb[$];

    ula_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_s       (op_s),
        .op_m       (op_m),
        .op_c_in    (op_c_in),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_s      (ula_s),
        .ula_m      (ula_m),
        .ula_c_in   (ula_c_in),
        .ula_b_in   (ula_b_in),
        .ula_f      (ula_f),
        .ula_c_out  (ula_c_out),
        .ula_a_eq_b (ula_a_eq_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_f      (res_f),
        .res_c_out  (res_c_out),
        .res_a_eq_b (res_a_eq_b)
`ifdef ULA_SEQ_ZERO_FLAG_EN
        ,
        .res_zero   (res_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_ready = bp_en ? rand_ready : man_ready;

    // 74181 logic-mode functions (active-high data).
    function automatic logic [15:0] logic16(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            4'b0000: return ~a;
            4'b0001: return ~(a | b);
            4'b0010: return ~a & b;
            4'b0011: return 16'h0000;
            4'b0100: return ~(a & b);
            4'b0101: return ~b;
            4'b0110: return a ^ b;
            4'b0111: return a & ~b;
            4'b1000: return ~a | b;
            4'b1001: return ~(a ^ b);
            4'b1010: return b;
            4'b1011: return a & b;
            4'b1100: return 16'hFFFF;
            4'b1101: return a | ~b;
            4'b1110: return a | b;
            default: return a;
        endcase
    endfunction

    // 74181 arithmetic functions expressed as F = p + x + carry_in.
    function automatic void terms16(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] p, output logic [15:0] x);
        case (s)
            4'b0000: begin p = a;      x = 16'h0000; end
            4'b0001: begin p = a | b;  x = 16'h0000; end
            4'b0010: begin p = a | ~b; x = 16'h0000; end
            4'b0011: begin p = 16'h0;  x = 16'hFFFF; end
            4'b0100: begin p = a;      x = a & ~b;   end
            4'b0101: begin p = a | b;  x = a & ~b;   end
            4'b0110: begin p = a;      x = ~b;       end
            4'b0111: begin p = a & ~b; x = 16'hFFFF; end
            4'b1000: begin p = a;      x = a & b;    end
            4'b1001: begin p = a;      x = b;        end
            4'b1010: begin p = a | ~b; x = a & b;    end
            4'b1011: begin p = a & b;  x = 16'hFFFF; end
            4'b1100: begin p = a;      x = a;        end
            4'b1101: begin p = a | b;  x = a;        end
            4'b1110: begin p = a | ~b; x = a;        end
            default: begin p = a;      x = 16'hFFFF; end
        endcase
    endfunction

    function automatic logic is_borrow(input logic [3:0] s);
        return (s == 4'b0110) || (s == 4'b0111) || (s == 4'b1011) || (s == 4'b1111);
    endfunction

    // One ULA nibble: returns {c_out, a_eq_b, f}; c_out is a raw borrow on subtract-style ops.
    function automatic logic [5:0] ula_nibble(input logic [3:0] s, input logic m, input logic [3:0] a,
                                              input logic [3:0] b, input logic cin);
        logic [15:0] t;
        logic [15:0] p;
        logic [15:0] x;
        logic [4:0]  sum;
        logic [3:0]  f;
        logic        c;
        if (m) begin
            t = logic16(s, {12'h0, a}, {12'h0, b});
            f = t[3:0];
            c = 1'b0;
        end else begin
            terms16(s, {12'h0, a}, {12'h0, b}, p, x);
            sum = {1'b0, p[3:0]} + {1'b0, x[3:0]} + {4'h0, cin};
            f   = sum[3:0];
            c   = sum[4] ^ is_borrow(s);
        end
        return {c, (a == b), f};
    endfunction

    // Behavioural ULA attached to the sequencer.
    always_comb begin
        {ula_c_out, ula_a_eq_b, ula_f} = ula_nibble(ula_s, ula_m, ula_a, ula_b, ula_c_in);
    end

    // Full-width reference: the whole command as one wide operation.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                                      input logic m, input logic cin,
                                      output logic [15:0] f, output logic c, output logic eq);
        logic [15:0] p;
        logic [15:0] x;
        logic [16:0] sum;
        eq = (a == b);
        if (m) begin
            f = logic16(s, a, b);
            c = 1'b0;
        end else if (s == 4'b0011) begin
            f = cin ? 16'h0000 : 16'hFFFF;
            c = cin;
        end else begin
            terms16(s, a, b, p, x);
            sum = {1'b0, p} + {1'b0, x} + {16'h0, cin};
            f   = sum[15:0];
            c   = sum[16] ^ is_borrow(s);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passes++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin, input logic use_exp,
                         input logic [15:0] ef, input logic ec, input logic eeq);
        exp_t e;
        int   n;
        if (use_exp) begin
            e.f  = ef;
            e.c  = ec;
            e.eq = eeq;
        end else begin
            ref_model(a, b, s, m, cin, e.f, e.c, e.eq);
        end
        op_a     = a;
        op_b     = b;
        op_s     = s;
        op_m     = m;
        op_c_in  = cin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end
        step();
        e.acc    = cyc;
        in_valid = 1'b0;
        sb.push_back(e);
        $display("cmd a=%h b=%h s=%b m=%b cin=%b -> f=%h c=%b eq=%b (accepted cycle %0d)",
                 a, b, s, m, cin, e.f, e.c, e.eq, e.acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            step();
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
        end
    endtask

    // Random consumer backpressure.
    initial begin
        rand_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rand_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        prev_valid;
        logic        prev_ready;
        logic [15:0] prev_f;
        logic        prev_c;
        logic        prev_eq;
        int          hs;
        int          acc;
        int          n;
        exp_t        e;

        checks     = 0;
        passes     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_s       = 4'd0;
        op_m       = 1'b0;
        op_c_in    = 1'b0;
        bp_en      = 1'b0;
        man_ready  = 1'b1;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_f     = '0;
        prev_c     = 1'b0;
        prev_eq    = 1'b0;

        fork
            // Monitor: compare on out_valid rise, check hold while stalled.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_valid = 1'b0;
                end else begin
                    if (out_valid && !prev_valid) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_result", 32'(out_valid), 32'd0);
                        end else begin
                            e = sb.pop_front();
                            $display("result f=%h c=%b eq=%b (expected f=%h c=%b eq=%b) cycle %0d",
                                     res_f, res_c_out, res_a_eq_b, e.f, e.c, e.eq, cyc);
                            chk("res_f", 32'(res_f), 32'(e.f));
                            chk("res_c_out", 32'(res_c_out), 32'(e.c));
                            chk("res_a_eq_b", 32'(res_a_eq_b), 32'(e.eq));
`ifdef ULA_SEQ_ZERO_FLAG_EN
                            chk("res_zero", 32'(res_zero), 32'(e.f == 16'h0));
`endif
                            chk("latency", 32'(cyc - e.acc), 32'(NIB));
                            chk("in_ready_in_done", 32'(in_ready), 32'd0);
                        end
                    end else if (out_valid && prev_valid && !prev_ready) begin
                        chk("hold_res_f", 32'(res_f), 32'(prev_f));
                        chk("hold_res_c_out", 32'(res_c_out), 32'(prev_c));
                        chk("hold_res_a_eq_b", 32'(res_a_eq_b), 32'(prev_eq));
                        chk("hold_in_ready", 32'(in_ready), 32'd0);
                    end
                    prev_valid = out_valid;
                    prev_ready = out_ready;
                    prev_f     = res_f;
                    prev_c     = res_c_out;
                    prev_eq    = res_a_eq_b;
                end
            end

            // Stimulus.
            begin
                #1;
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_res_f", 32'(res_f), 32'd0);
                chk("rst_res_c_out", 32'(res_c_out), 32'd0);
                chk("rst_res_a_eq_b", 32'(res_a_eq_b), 32'd0);
                chk("rst_ula_a", 32'(ula_a), 32'd0);
                chk("rst_ula_b_in", 32'(ula_b_in), 32'd0);
                step();
                step();
                rst_n = 1'b1;
                step();

                // Directed cases with hand-computed expectations.
                issue(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
                issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
                issue(16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b1, 1'b1, 16'h0FFF, 1'b0, 1'b0);
                issue(16'h0001, 16'h0002, 4'b0110, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
                issue(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 1'b1, 16'hAA55, 1'b0, 1'b0);
                issue(16'h1234, 16'h1234, 4'b0110, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
                issue(16'h1235, 16'h1234, 4'b0110, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
                drain();

                // Backpressure in DONE with a competing command waiting.
                man_ready = 1'b0;
                issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
                op_a     = 16'h0F0F;
                op_b     = 16'h0101;
                op_s     = 4'b1001;
                op_m     = 1'b0;
                op_c_in  = 1'b0;
                in_valid = 1'b1;
                n = 0;
                while (!out_valid && n < 50) begin
                    step();
                    n++;
                end
                chk("stall_reach_done", 32'(out_valid), 32'd1);
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                man_ready = 1'b1;
                step();
                hs = cyc;
                chk("release_in_ready", 32'(in_ready), 32'd1);
                step();
                acc = cyc;
                in_valid = 1'b0;
                chk("bubble_accept", 32'(acc - hs), 32'd1);
                e.f   = 16'h1010;
                e.c   = 1'b0;
                e.eq  = 1'b0;
                e.acc = acc;
                sb.push_back(e);
                $display("cmd a=0f0f b=0101 s=1001 m=0 cin=0 -> f=1010 (accepted cycle %0d)", acc);
                drain();

                // Reset in the middle of RUN at idx 2.
                issue(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
                step();
                step();
                rst_n = 1'b0;
                #1;
                sb.delete();
                chk("midrst_out_valid", 32'(out_valid), 32'd0);
                chk("midrst_res_f", 32'(res_f), 32'd0);
                chk("midrst_ula_a", 32'(ula_a), 32'd0);
                chk("midrst_ula_s", 32'(ula_s), 32'd0);
                chk("midrst_in_ready", 32'(in_ready), 32'd1);
                step();
                rst_n = 1'b1;
                step();
                chk("postrst_in_ready", 32'(in_ready), 32'd1);
                chk("postrst_res_f", 32'(res_f), 32'd0);
                chk("postrst_ula_b", 32'(ula_b), 32'd0);
                chk("postrst_ula_c_in", 32'(ula_c_in), 32'd0);
                chk("postrst_res_c_out", 32'(res_c_out), 32'd0);
                issue(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
                drain();

                // Random commands with random backpressure.
                bp_en = 1'b1;
                for (int i = 0; i < 60; i++) begin
                    ra = 16'($urandom);
                    rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
                    issue(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0, 16'h0, 1'b0, 1'b0);
                end
                drain();
                bp_en = 1'b0;

                $display("%0d/%0d checks passed", passes, checks);
                $finish;
            end
        join
    end

endmodule
